pipeline_reg_wb_fwd: RTL and testbench

- Parametrised MEM->WB pipeline register for the RISC-V core. Adds the following to the plain stage register:
  - valid bit, stall and flush control;
  - a HIST_DEPTH-entry history of retired writes;
  - an NUM_SRC-port forwarding lookup;
  - a retired-instruction counter.
- Sits between the memory stage and the register file.
- Its forwarding outputs feed the decode/execute operand muxes.

---
 rtl/rv_pipe_pkg.sv | 21 ++
 rtl/fwd_lookup.sv | 33 +++
 rtl/pipeline_reg_wb_fwd.sv | 120 ++++++++++++
 tb/tb_pipeline_reg_wb_fwd.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the RISC-V core: register-address width, default data
// width and the stage-register entry layout.
package rv_pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN_DEF   = 32;

  typedef struct packed {
    logic                  valid;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] rd_sel;
    logic [XLEN_DEF-1:0]   rd_val;
  } wb_entry_t;

  // A write is visible to later readers only if it is real, enabled and not to x0.
  function automatic logic wr_commits(input logic valid, input logic wr_en,
                                      input logic [REG_ADDR_W-1:0] sel);
    return valid & wr_en & (sel != '0);
  endfunction

endpackage

// File: rtl/fwd_lookup.sv
// Single-port forwarding matcher: scans candidates in priority order (index 0 newest) and
// returns the value of the first valid candidate whose destination equals src_sel.
module fwd_lookup
  import rv_pipe_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NUM_CAND = 4
) (
  input  logic [NUM_CAND-1:0]            cand_valid,
  input  logic [NUM_CAND*REG_ADDR_W-1:0] cand_sel,
  input  logic [NUM_CAND*XLEN-1:0]       cand_val,
  input  logic [REG_ADDR_W-1:0]          src_sel,
  output logic                           hit,
  output logic [XLEN-1:0]                val
);

  always_comb begin
    hit = 1'b0;
    val = '0;
    // Walk oldest to newest so the newest matching candidate overrides.
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (cand_valid[i] && (cand_sel[i*REG_ADDR_W +: REG_ADDR_W] == src_sel)) begin
        hit = 1'b1;
        val = cand_val[i*XLEN +: XLEN];
      end
    end
    if (src_sel == '0) begin
      hit = 1'b0;
      val = '0;
    end
  end

endmodule

// File: rtl/pipeline_reg_wb_fwd.sv
// MEM->WB pipeline register with stall/flush, a short history of retired writes,
// multi-port operand forwarding and a retired-instruction counter.
module pipeline_reg_wb_fwd
  import rv_pipe_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned HIST_DEPTH = 2,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          MEM_valid,
  input  logic                          MEM_wr_en,
  input  logic [REG_ADDR_W-1:0]         MEM_rd_sel,
  input  logic [XLEN-1:0]               MEM_rd_val,
  output logic                          WB_valid,
  output logic                          WB_wr_en,
  output logic [REG_ADDR_W-1:0]         WB_rd_sel,
  output logic [XLEN-1:0]               WB_rd_val,
  output logic                          WB_raw_wr_en,
  output logic [REG_ADDR_W-1:0]         WB_raw_sel,
  output logic [XLEN-1:0]               WB_raw_val,
  input  logic [REG_ADDR_W*NUM_SRC-1:0] src_sel,
  output logic [NUM_SRC-1:0]            fwd_hit,
  output logic [XLEN*NUM_SRC-1:0]       fwd_val,
  output logic [CNT_W-1:0]              retire_cnt
);

  localparam int unsigned NumCand = HIST_DEPTH + 2;

  logic                  wb_valid_q;
  logic                  wb_wr_en_q;
  logic [REG_ADDR_W-1:0] wb_sel_q;
  logic [XLEN-1:0]       wb_val_q;

  logic [HIST_DEPTH-1:0] hist_valid_q;
  logic [REG_ADDR_W-1:0] hist_sel_q [HIST_DEPTH];
  logic [XLEN-1:0]       hist_val_q [HIST_DEPTH];

  logic [CNT_W-1:0]      retire_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q   <= 1'b0;
      wb_wr_en_q   <= 1'b0;
      wb_sel_q     <= '0;
      wb_val_q     <= '0;
      hist_valid_q <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_sel_q[i] <= '0;
        hist_val_q[i] <= '0;
      end
      retire_cnt_q <= '0;
    end else if (!stall) begin
      // Flush only kills the incoming MEM op; the retiring WB op still enters history.
      wb_valid_q      <= MEM_valid & ~flush;
      wb_wr_en_q      <= MEM_wr_en;
      wb_sel_q        <= MEM_rd_sel;
      wb_val_q        <= MEM_rd_val;
      hist_valid_q[0] <= wr_commits(wb_valid_q, wb_wr_en_q, wb_sel_q);
      hist_sel_q[0]   <= wb_sel_q;
      hist_val_q[0]   <= wb_val_q;
      for (int i = 1; i < HIST_DEPTH; i++) begin
        hist_valid_q[i] <= hist_valid_q[i-1];
        hist_sel_q[i]   <= hist_sel_q[i-1];
        hist_val_q[i]   <= hist_val_q[i-1];
      end
      retire_cnt_q <= retire_cnt_q + CNT_W'(wb_valid_q);
    end
  end

  assign WB_valid     = wb_valid_q;
  assign WB_wr_en     = wb_valid_q & wb_wr_en_q;
  assign WB_rd_sel    = wb_sel_q;
  assign WB_rd_val    = wb_val_q;
  assign WB_raw_wr_en = MEM_valid & MEM_wr_en & ~flush;
  assign WB_raw_sel   = MEM_rd_sel;
  assign WB_raw_val   = MEM_rd_val;
  assign retire_cnt   = retire_cnt_q;

  logic [NumCand-1:0]            cand_valid;
  logic [NumCand*REG_ADDR_W-1:0] cand_sel;
  logic [NumCand*XLEN-1:0]       cand_val;

  // Candidate order: MEM raw, WB, then history newest to oldest.
  always_comb begin
    cand_valid    = '0;
    cand_sel      = '0;
    cand_val      = '0;
    cand_valid[0] = WB_raw_wr_en;
    cand_sel[0 +: REG_ADDR_W] = MEM_rd_sel;
    cand_val[0 +: XLEN]       = MEM_rd_val;
    cand_valid[1] = WB_wr_en;
    cand_sel[REG_ADDR_W +: REG_ADDR_W] = wb_sel_q;
    cand_val[XLEN +: XLEN]             = wb_val_q;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      cand_valid[i+2] = hist_valid_q[i];
      cand_sel[(i+2)*REG_ADDR_W +: REG_ADDR_W] = hist_sel_q[i];
      cand_val[(i+2)*XLEN +: XLEN]             = hist_val_q[i];
    end
  end

  for (genvar p = 0; p < NUM_SRC; p++) begin : g_port
    fwd_lookup #(
      .XLEN     (XLEN),
      .NUM_CAND (NumCand)
    ) u_fwd_lookup (
      .cand_valid (cand_valid),
      .cand_sel   (cand_sel),
      .cand_val   (cand_val),
      .src_sel    (src_sel[p*REG_ADDR_W +: REG_ADDR_W]),
      .hit        (fwd_hit[p]),
      .val        (fwd_val[p*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_pipeline_reg_wb_fwd.sv
// Self-checking bench for pipeline_reg_wb_fwd: WB stage scoreboard plus directed
// forwarding, stall/flush, reset and counter-wrap checks.
module tb_pipeline_reg_wb_fwd;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CNT_W = 4;

  logic              clk;
  logic              rst_n;
  logic              stall;
  logic              flush;
  logic              MEM_valid;
  logic              MEM_wr_en;
  logic [4:0]        MEM_rd_sel;
  logic [XLEN-1:0]   MEM_rd_val;
  logic              WB_valid;
  logic              WB_wr_en;
  logic [4:0]        WB_rd_sel;
  logic [XLEN-1:0]   WB_rd_val;
  logic              WB_raw_wr_en;
  logic [4:0]        WB_raw_sel;
  logic [XLEN-1:0]   WB_raw_val;
  logic [9:0]        src_sel;
  logic [1:0]        fwd_hit;
  logic [2*XLEN-1:0] fwd_val;
  logic [CNT_W-1:0]  retire_cnt;

  pipeline_reg_wb_fwd #(
    .XLEN       (XLEN),
    .HIST_DEPTH (2),
    .NUM_SRC    (2),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .MEM_valid    (MEM_valid),
    .MEM_wr_en    (MEM_wr_en),
    .MEM_rd_sel   (MEM_rd_sel),
    .MEM_rd_val   (MEM_rd_val),
    .WB_valid     (WB_valid),
    .WB_wr_en     (WB_wr_en),
    .WB_rd_sel    (WB_rd_sel),
    .WB_rd_val    (WB_rd_val),
    .WB_raw_wr_en (WB_raw_wr_en),
    .WB_raw_sel   (WB_raw_sel),
    .WB_raw_val   (WB_raw_val),
    .src_sel      (src_sel),
    .fwd_hit      (fwd_hit),
    .fwd_val      (fwd_val),
    .retire_cnt   (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             valid;
    logic             wr_en;
    logic [4:0]       sel;
    logic [XLEN-1:0]  val;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             last_wb;
  logic [CNT_W-1:0] m_cnt;
  int               n_total;
  int               n_bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    last_wb = '0;
    m_cnt   = '0;
    sb_q.delete();
  endtask

  // Drive one MEM op (held across the next edge), check raw outputs, then the WB result.
  task automatic adv(input logic v, input logic we, input logic [4:0] sel,
                     input logic [XLEN-1:0] val, input logic st, input logic fl);
    exp_t e;
    exp_t got;
    MEM_valid  = v;
    MEM_wr_en  = we;
    MEM_rd_sel = sel;
    MEM_rd_val = val;
    stall      = st;
    flush      = fl;
    #1;
    check("raw_wr_en", 64'(WB_raw_wr_en), 64'(v & we & ~fl));
    check("raw_sel", 64'(WB_raw_sel), 64'(sel));
    check("raw_val", 64'(WB_raw_val), 64'(val));
    if (st) begin
      e = last_wb;
    end else begin
      if (last_wb.valid) m_cnt = m_cnt + 1'b1;
      e.valid = v & ~fl;
      e.wr_en = we;
      e.sel   = sel;
      e.val   = val;
    end
    e.cnt = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      got = sb_q.pop_front();
      check("wb_valid", 64'(WB_valid), 64'(got.valid));
      check("wb_wr_en", 64'(WB_wr_en), 64'(got.valid & got.wr_en));
      check("wb_rd_sel", 64'(WB_rd_sel), 64'(got.sel));
      check("wb_rd_val", 64'(WB_rd_val), 64'(got.val));
      check("retire_cnt", 64'(retire_cnt), 64'(got.cnt));
    end
    last_wb = e;
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_valid"}, 64'(WB_valid), 64'd0);
    check({tag, "_wr_en"}, 64'(WB_wr_en), 64'd0);
    check({tag, "_sel"}, 64'(WB_rd_sel), 64'd0);
    check({tag, "_val"}, 64'(WB_rd_val), 64'd0);
    check({tag, "_cnt"}, 64'(retire_cnt), 64'd0);
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_zero("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total    = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    MEM_valid  = 1'b0;
    MEM_wr_en  = 1'b0;
    MEM_rd_sel = '0;
    MEM_rd_val = '0;
    src_sel    = '0;
    model_reset();
    #12;
    check_reset_zero("por");
    rst_n = 1'b1;

    // Mid-stream asynchronous reset; raw path stays live.
    adv(1'b1, 1'b1, 5'd3, 32'h1234_5678, 1'b0, 1'b0);
    adv(1'b1, 1'b1, 5'd4, 32'h0BAD_F00D, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_zero("mid_rst");
    check("rst_raw_val", 64'(WB_raw_val), 64'h0BAD_F00D);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Five valid instructions, counter lags by one edge.
    for (int i = 1; i <= 5; i++) adv(1'b1, 1'b1, 5'(i), 32'(i * 256), 1'b0, 1'b0);
    check("cnt_after5", 64'(retire_cnt), 64'd4);
    adv(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check("cnt_after6", 64'(retire_cnt), 64'd5);

    // Basic pass.
    adv(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("basic_wr_en", 64'(WB_wr_en), 64'd1);
    check("basic_val", 64'(WB_rd_val), 64'hDEAD_BEEF);

    // Priority among MEM, WB and history.
    adv(1'b1, 1'b1, 5'd7, 32'h11, 1'b0, 1'b0);
    adv(1'b1, 1'b1, 5'd7, 32'h22, 1'b0, 1'b0);
    adv(1'b1, 1'b1, 5'd7, 32'h33, 1'b0, 1'b0);
    MEM_valid  = 1'b1;
    MEM_wr_en  = 1'b1;
    MEM_rd_sel = 5'd7;
    MEM_rd_val = 32'h44;
    src_sel    = {5'd0, 5'd7};
    #1;
    check("prio_mem_hit", 64'(fwd_hit[0]), 64'd1);
    check("prio_mem_val", 64'(fwd_val[31:0]), 64'h44);
    MEM_valid = 1'b0;
    #1;
    check("prio_wb_val", 64'(fwd_val[31:0]), 64'h33);
    adv(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check("prio_h0_val", 64'(fwd_val[31:0]), 64'h33);
    adv(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check("prio_h1_val", 64'(fwd_val[31:0]), 64'h33);
    adv(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check("prio_gone_hit", 64'(fwd_hit[0]), 64'd0);
    check("prio_gone_val", 64'(fwd_val[31:0]), 64'd0);

    // x0 never forwards.
    MEM_valid  = 1'b1;
    MEM_wr_en  = 1'b1;
    MEM_rd_sel = 5'd0;
    MEM_rd_val = 32'hFF;
    #1;
    check("x0_mem_hit", 64'(fwd_hit[1]), 64'd0);
    check("x0_mem_val", 64'(fwd_val[63:32]), 64'd0);
    adv(1'b1, 1'b1, 5'd0, 32'hFF, 1'b0, 1'b0);
    check("x0_wb_hit", 64'(fwd_hit[1]), 64'd0);
    adv(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check("x0_hist_hit", 64'(fwd_hit[1]), 64'd0);
    check("x0_hist_val", 64'(fwd_val[63:32]), 64'd0);

    // Stall and flush interaction.
    src_sel = {5'd9, 5'd10};
    adv(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) adv(1'b1, 1'b1, 5'd10, 32'hAA, 1'b1, 1'b0);
    check("stall_fwd_wb", 64'(fwd_val[63:32]), 64'h99);
    check("stall_fwd_raw", 64'(fwd_val[31:0]), 64'hAA);
    adv(1'b1, 1'b1, 5'd10, 32'hAA, 1'b1, 1'b1);
    check("stfl_valid", 64'(WB_valid), 64'd1);
    adv(1'b1, 1'b1, 5'd10, 32'hAA, 1'b0, 1'b1);
    check("flush_valid", 64'(WB_valid), 64'd0);
    check("flush_h0_hit", 64'(fwd_hit[1]), 64'd1);
    check("flush_h0_val", 64'(fwd_val[63:32]), 64'h99);
    check("flush_raw_off", 64'(fwd_hit[0]), 64'd0);

    // Counter wrap at CNT_W=4.
    do_reset();
    for (int i = 0; i < 17; i++) adv(1'b1, 1'b1, 5'(i + 1), 32'(i), 1'b0, 1'b0);
    adv(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check("cnt_wrap", 64'(retire_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
